// File: rtl/zigzag_reorder_buffer.sv
// rtl/zigzag_reorder_buffer.sv - double-buffered N x N zigzag/raster reorder stage
module zigzag_reorder_buffer #(
    parameter int DWIDTH    = 12,
    parameter int BLOCK_DIM = 8,
    parameter int IDX_W     = $clog2(BLOCK_DIM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DWIDTH-1:0] in_data,
    input  logic              in_mode,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic              out_sob,
    output logic              out_eob
);

    localparam int BLK = BLOCK_DIM * BLOCK_DIM;
    localparam int AW  = 2 * IDX_W;
    localparam logic [AW-1:0]    LAST_IDX = AW'(BLK - 1);
    localparam logic [IDX_W-1:0] EDGE_IDX = IDX_W'(BLOCK_DIM - 1);

    typedef enum logic [1:0] {
        B_FREE,
        B_FILLING,
        B_FULL,
        B_DRAINING
    } bank_state_t;

    bank_state_t bank_q [2];
    bank_state_t bank_d [2];
    logic [1:0]  mode_q, mode_d;
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [AW-1:0]    wr_cnt_q, wr_cnt_d;
    logic [AW-1:0]    rd_cnt_q, rd_cnt_d;
    logic [IDX_W-1:0] row_q, row_d;
    logic [IDX_W-1:0] col_q, col_d;
    logic             up_q, up_d;
    logic             rd_v_q, rd_v_d;
    logic             rd_sob_q, rd_sob_d;
    logic             rd_eob_q, rd_eob_d;
    logic              out_valid_q, out_valid_d;
    logic              out_sob_q, out_sob_d;
    logic              out_eob_q, out_eob_d;
    logic [DWIDTH-1:0] out_data_q, out_data_d;

    logic [DWIDTH-1:0] mem [0:2*BLK-1];
    logic [DWIDTH-1:0] mem_rdata;

    logic             wr_fire;
    logic             out_load;
    logic             rd_avail;
    logic             rd_issue;
    logic             rd_last;
    logic [AW-1:0]    rd_addr;
    logic [IDX_W-1:0] walk_row, walk_col;
    logic             walk_up;

    assign in_ready  = (bank_q[wr_ptr_q] == B_FREE) || (bank_q[wr_ptr_q] == B_FILLING);
    assign wr_fire   = in_valid && in_ready;
    assign out_load  = !out_valid_q || out_ready;
    assign rd_avail  = (bank_q[rd_ptr_q] == B_FULL) || (bank_q[rd_ptr_q] == B_DRAINING);
    // A read may only be issued when the memory output stage can hand its word on.
    assign rd_issue  = rd_avail && (!rd_v_q || out_load);
    assign rd_last   = (rd_cnt_q == LAST_IDX);
    assign rd_addr   = mode_q[rd_ptr_q] ? rd_cnt_q : {row_q, col_q};

    always_comb begin
        walk_row = row_q;
        walk_col = col_q;
        walk_up  = up_q;
        if (up_q) begin
            if (col_q == EDGE_IDX) begin
                walk_row = row_q + IDX_W'(1);
                walk_up  = 1'b0;
            end else if (row_q == '0) begin
                walk_col = col_q + IDX_W'(1);
                walk_up  = 1'b0;
            end else begin
                walk_row = row_q - IDX_W'(1);
                walk_col = col_q + IDX_W'(1);
            end
        end else begin
            if (row_q == EDGE_IDX) begin
                walk_col = col_q + IDX_W'(1);
                walk_up  = 1'b1;
            end else if (col_q == '0) begin
                walk_row = row_q + IDX_W'(1);
                walk_up  = 1'b1;
            end else begin
                walk_row = row_q + IDX_W'(1);
                walk_col = col_q - IDX_W'(1);
            end
        end
    end

    always_comb begin
        bank_d[0]   = bank_q[0];
        bank_d[1]   = bank_q[1];
        mode_d      = mode_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        wr_cnt_d    = wr_cnt_q;
        rd_cnt_d    = rd_cnt_q;
        row_d       = row_q;
        col_d       = col_q;
        up_d        = up_q;
        rd_v_d      = rd_v_q;
        rd_sob_d    = rd_sob_q;
        rd_eob_d    = rd_eob_q;
        out_valid_d = out_valid_q;
        out_sob_d   = out_sob_q;
        out_eob_d   = out_eob_q;
        out_data_d  = out_data_q;

        // Write side only touches FREE/FILLING banks, read side only FULL/DRAINING,
        // so both updates below never target the same bank in one cycle.
        if (wr_fire) begin
            if (bank_q[wr_ptr_q] == B_FREE) begin
                bank_d[wr_ptr_q] = B_FILLING;
                mode_d[wr_ptr_q] = in_mode;
            end
            if (wr_cnt_q == LAST_IDX) begin
                bank_d[wr_ptr_q] = B_FULL;
                wr_ptr_d         = !wr_ptr_q;
                wr_cnt_d         = '0;
            end else begin
                wr_cnt_d = wr_cnt_q + AW'(1);
            end
        end

        if (bank_q[rd_ptr_q] == B_FULL) begin
            bank_d[rd_ptr_q] = B_DRAINING;
        end

        if (rd_issue) begin
            if (rd_last) begin
                bank_d[rd_ptr_q] = B_FREE;
                rd_ptr_d         = !rd_ptr_q;
                rd_cnt_d         = '0;
                row_d            = '0;
                col_d            = '0;
                up_d             = 1'b1;
            end else begin
                rd_cnt_d = rd_cnt_q + AW'(1);
                row_d    = walk_row;
                col_d    = walk_col;
                up_d     = walk_up;
            end
        end

        if (rd_issue) begin
            rd_v_d   = 1'b1;
            rd_sob_d = (rd_cnt_q == '0);
            rd_eob_d = rd_last;
        end else if (out_load) begin
            rd_v_d = 1'b0;
        end

        if (out_load) begin
            out_valid_d = rd_v_q;
            if (rd_v_q) begin
                out_data_d = mem_rdata;
                out_sob_d  = rd_sob_q;
                out_eob_d  = rd_eob_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_fire) begin
            mem[{wr_ptr_q, wr_cnt_q}] <= in_data;
        end
        if (rd_issue) begin
            mem_rdata <= mem[{rd_ptr_q, rd_addr}];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_q[0]   <= B_FREE;
            bank_q[1]   <= B_FREE;
            mode_q      <= '0;
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            row_q       <= '0;
            col_q       <= '0;
            up_q        <= 1'b1;
            rd_v_q      <= 1'b0;
            rd_sob_q    <= 1'b0;
            rd_eob_q    <= 1'b0;
            out_valid_q <= 1'b0;
            out_sob_q   <= 1'b0;
            out_eob_q   <= 1'b0;
            out_data_q  <= '0;
        end else begin
            bank_q[0]   <= bank_d[0];
            bank_q[1]   <= bank_d[1];
            mode_q      <= mode_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_cnt_q    <= wr_cnt_d;
            rd_cnt_q    <= rd_cnt_d;
            row_q       <= row_d;
            col_q       <= col_d;
            up_q        <= up_d;
            rd_v_q      <= rd_v_d;
            rd_sob_q    <= rd_sob_d;
            rd_eob_q    <= rd_eob_d;
            out_valid_q <= out_valid_d;
            out_sob_q   <= out_sob_d;
            out_eob_q   <= out_eob_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_sob   = out_sob_q;
    assign out_eob   = out_eob_q;

endmodule

// File: tb/tb_zigzag_reorder_buffer.sv
// tb/tb_zigzag_reorder_buffer.sv - scoreboard bench for zigzag_reorder_buffer (N=8 and N=4)
module tb_zigzag_reorder_buffer;

    typedef struct {
        logic [11:0] data;
        logic        sob;
        logic        eob;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic        in_valid8 = 1'b0, in_mode8 = 1'b0, out_ready8 = 1'b1;
    logic [11:0] in_data8 = '0;
    logic        in_ready8, out_valid8, out_sob8, out_eob8;
    logic [11:0] out_data8;

    logic        in_valid4 = 1'b0, in_mode4 = 1'b0, out_ready4 = 1'b1;
    logic [11:0] in_data4 = '0;
    logic        in_ready4, out_valid4, out_sob4, out_eob4;
    logic [11:0] out_data4;

    zigzag_reorder_buffer #(.DWIDTH(12), .BLOCK_DIM(8)) u8 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_data(in_data8), .in_mode(in_mode8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_data(out_data8),
        .out_sob(out_sob8), .out_eob(out_eob8)
    );

    zigzag_reorder_buffer #(.DWIDTH(12), .BLOCK_DIM(4)) u4 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data4), .in_mode(in_mode4),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4),
        .out_sob(out_sob4), .out_eob(out_eob4)
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_err = 0;
    exp_t sb [2][$];
    int   rmode [2];
    int   accepted [2];
    int   pops [2];
    logic held [2];
    logic [11:0] hd [2];
    logic hs [2];
    logic he [2];
    int   dat [2][256];
    logic done3;

    // k-th raster index of the zigzag scan: walk anti-diagonals d=r+c, odd ones top-down,
    // even ones bottom-up.
    function automatic int zz(input int n, input int k);
        int cnt = 0;
        for (int d = 0; d <= 2 * n - 2; d++) begin
            for (int j = 0; j <= d; j++) begin
                int r = (d % 2 == 1) ? j : d - j;
                int c = d - r;
                if (r < n && c < n) begin
                    if (cnt == k) return r * n + c;
                    cnt++;
                end
            end
        end
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic monitor_step(input int id, input logic v, input logic r,
                                input logic [11:0] d, input logic s, input logic e);
        exp_t x;
        if (rst) begin
            held[id] = 1'b0;
            return;
        end
        if (held[id]) begin
            n_checks++;
            if (!v || d !== hd[id] || s !== hs[id] || e !== he[id]) begin
                n_err++;
                $display("FAIL stall_hold inst%0d: got v=%0b d=%0d sob=%0b eob=%0b, expected v=1 d=%0d sob=%0b eob=%0b",
                         id, v, d, s, e, hd[id], hs[id], he[id]);
            end
        end
        if (v && r) begin
            if (sb[id].size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL unexpected_output inst%0d: got data %0d, expected no output", id, d);
            end else begin
                x = sb[id].pop_front();
                pops[id]++;
                check($sformatf("data inst%0d", id), int'(d), int'(x.data));
                check($sformatf("sob inst%0d", id), int'(s), int'(x.sob));
                check($sformatf("eob inst%0d", id), int'(e), int'(x.eob));
            end
        end
        held[id] = v && !r;
        hd[id] = d;
        hs[id] = s;
        he[id] = e;
    endtask

    always @(negedge clk) begin
        monitor_step(0, out_valid8, out_ready8, out_data8, out_sob8, out_eob8);
        monitor_step(1, out_valid4, out_ready4, out_data4, out_sob4, out_eob4);
    end

    always begin
        @(posedge clk);
        #1;
        out_ready8 = (rmode[0] == 0) ? 1'b1 : (rmode[0] == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        out_ready4 = (rmode[1] == 0) ? 1'b1 : (rmode[1] == 1) ? 1'b0 : 1'($urandom_range(0, 1));
    end

    task automatic drive(input int id, input logic v, input logic [11:0] d, input logic m);
        if (id == 0) begin
            in_valid8 = v; in_data8 = d; in_mode8 = m;
        end else begin
            in_valid4 = v; in_data4 = d; in_mode4 = m;
        end
    endtask

    function automatic logic rdy(input int id);
        return (id == 0) ? in_ready8 : in_ready4;
    endfunction

    function automatic logic ovalid(input int id);
        return (id == 0) ? out_valid8 : out_valid4;
    endfunction

    task automatic send_block(input int id, input int mode, input bit toggle,
                              input int count, input bit push);
        int   n = (id == 0) ? 8 : 4;
        int   nn = n * n;
        int   t;
        logic m;
        exp_t x;
        for (int k = 0; k < count; k++) begin
            m = mode[0];
            if (toggle && k >= nn / 2) m = ~m;
            drive(id, 1'b1, 12'(dat[id][k]), m);
            @(negedge clk);
            t = 0;
            while (!rdy(id) && t < 2000) begin
                @(negedge clk);
                t++;
            end
            if (!rdy(id)) begin
                n_checks++;
                n_err++;
                $display("FAIL accept_timeout inst%0d sample %0d: in_ready got 0, expected 1", id, k);
                drive(id, 1'b0, 12'd0, 1'b0);
                return;
            end
            @(posedge clk);
            #1;
            accepted[id]++;
        end
        drive(id, 1'b0, 12'd0, 1'b0);
        if (push && count == nn) begin
            for (int k = 0; k < nn; k++) begin
                x.data = 12'(dat[id][(mode != 0) ? k : zz(n, k)]);
                x.sob  = (k == 0);
                x.eob  = (k == nn - 1);
                sb[id].push_back(x);
            end
        end
    endtask

    task automatic wait_empty(input int id, input int budget);
        int t = 0;
        while ((sb[id].size() != 0 || ovalid(id)) && t < budget) begin
            @(negedge clk);
            t++;
        end
        check($sformatf("drain_left inst%0d", id), sb[id].size(), 0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int cyc;
        int p0;
        int t;
        rmode[0] = 0; rmode[1] = 0;
        accepted[0] = 0; accepted[1] = 0;
        pops[0] = 0; pops[1] = 0;
        held[0] = 1'b0; held[1] = 1'b0;
        done3 = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("reset out_valid8", out_valid8, 0);
        check("reset out_sob8", out_sob8, 0);
        check("reset out_eob8", out_eob8, 0);
        check("reset out_data8", out_data8, 0);
        check("reset in_ready8", in_ready8, 1);
        check("reset out_valid4", out_valid4, 0);
        check("reset in_ready4", in_ready4, 1);
        @(posedge clk);
        #1;

        // zigzag 0..63, then latency from last accept to out_valid
        for (int k = 0; k < 64; k++) dat[0][k] = k;
        send_block(0, 0, 1'b0, 64, 1'b1);
        cyc = 0;
        while (!out_valid8 && cyc < 10) begin
            @(negedge clk);
            if (!out_valid8) cyc++;
        end
        check("first_out_latency", cyc, 2);
        wait_empty(0, 500);

        // raster bypass 100..163
        for (int k = 0; k < 64; k++) dat[0][k] = 100 + k;
        send_block(0, 1, 1'b0, 64, 1'b1);
        wait_empty(0, 500);

        // three blocks with output stalled
        rmode[0] = 1;
        accepted[0] = 0;
        p0 = pops[0];
        fork
            begin
                for (int b = 0; b < 3; b++) begin
                    for (int k = 0; k < 64; k++) dat[0][k] = b * 64 + k;
                    send_block(0, 0, 1'b0, 64, 1'b1);
                end
                done3 = 1'b1;
            end
        join_none
        repeat (200) @(posedge clk);
        @(negedge clk);
        check("accepts_while_stalled", accepted[0], 128);
        check("in_ready_while_stalled", in_ready8, 0);
        rmode[0] = 0;
        t = 0;
        while (!done3 && t < 2000) begin
            @(negedge clk);
            t++;
        end
        check("third_block_written", done3, 1);
        wait_empty(0, 1000);
        check("outputs_three_blocks", pops[0] - p0, 192);

        // reset while block 1 drains and block 2 is partly written
        for (int k = 0; k < 64; k++) dat[0][k] = k;
        send_block(0, 0, 1'b0, 64, 1'b1);
        for (int k = 0; k < 30; k++) dat[0][k] = 500 + k;
        send_block(0, 0, 1'b0, 30, 1'b0);
        rst = 1'b1;
        sb[0].delete();
        sb[1].delete();
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset out_valid8", out_valid8, 0);
        check("post_reset in_ready8", in_ready8, 1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) dat[0][k] = k;
        send_block(0, 0, 1'b0, 64, 1'b1);
        wait_empty(0, 500);

        // alternating modes with in_mode flipped mid-block, random backpressure
        rmode[0] = 2;
        for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < 64; k++) dat[0][k] = int'($urandom_range(0, 4095));
            send_block(0, b % 2, 1'b1, 64, 1'b1);
        end
        wait_empty(0, 3000);

        // N=4, random backpressure, continuous input
        rmode[1] = 2;
        for (int b = 0; b < 6; b++) begin
            for (int k = 0; k < 16; k++) dat[1][k] = int'($urandom_range(0, 4095));
            send_block(1, (b == 5) ? 1 : 0, 1'b0, 16, 1'b1);
        end
        wait_empty(1, 2000);

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_err);
        $finish;
    end

endmodule
